// File: rtl/uart_boot_loader_if.sv
// Memory request handshake between the boot loader (initiator) and a RAM or
// interconnect port (responder).
interface uart_boot_loader_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: 4-byte little-endian length header, then payload written as words.
// Define UART_BOOT_LOADER_VERIFY_EN to read back and compare every written word.
module uart_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx,
    uart_boot_loader_if.master mem,
    output logic               done,
    output logic               error
);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {ST_HDR, ST_DATA, ST_DRAIN, ST_DONE, ST_ERR} state_t;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_stb, frame_err;

    state_t        state_q, state_d;
    logic [31:0]   len_q, len_d, cnt_q, cnt_d, asm_q, asm_d;
    logic [1:0]    hdr_idx_q, hdr_idx_d;
    logic          req_full_q, req_full_d, mem_valid_q, mem_valid_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   word;
    logic [1:0]    lane;
    logic          last, handshake, req_release, mismatch;

`ifdef UART_BOOT_LOADER_VERIFY_EN
    logic          phase_q, phase_d;
    logic [31:0]   lane_mask;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
        assign lane_mask[8*gi +: 8] = {8{wstrb_q[gi]}};
    end
`endif

    // ---------------- UART receiver ----------------
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (clk_cnt_q == HALF_LAST) begin
                // A start bit that is high again at mid-bit was a glitch.
                clk_cnt_d  = '0;
                bit_idx_d  = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (clk_cnt_q == BIT_LAST) begin
                clk_cnt_d = '0;
                shift_d   = {rx_sync_q, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 1'b1;
                if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (clk_cnt_q == BIT_LAST) begin
                rx_state_d = RX_IDLE;
                byte_stb   = rx_sync_q;
                frame_err  = !rx_sync_q;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- Loader and bus initiator ----------------
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        hdr_idx_d   = hdr_idx_q;
        req_full_d  = req_full_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        mismatch    = 1'b0;
        lane        = cnt_q[1:0];
        last        = (cnt_q == len_q - 32'd1);
        word        = asm_q;
        word[{lane, 3'b000} +: 8] = shift_q;
        handshake   = mem_valid_q && mem.mem_ready;
        req_release = 1'b0;
`ifdef UART_BOOT_LOADER_VERIFY_EN
        phase_d = phase_q;
        if (handshake) begin
            phase_d = !phase_q;
            if (phase_q) begin
                req_release = 1'b1;
                req_full_d  = 1'b0;
                addr_d      = addr_q + 32'd4;
                mismatch    = ((mem.mem_rdata ^ wdata_q) & lane_mask) != 32'd0;
            end
        end
`else
        if (handshake) begin
            req_release = 1'b1;
            req_full_d  = 1'b0;
            addr_d      = addr_q + 32'd4;
        end
`endif
        case (state_q)
            ST_HDR: if (byte_stb) begin
                len_d[{hdr_idx_q, 3'b000} +: 8] = shift_q;
                hdr_idx_d = hdr_idx_q + 1'b1;
                cnt_d     = '0;
                if (hdr_idx_q == 2'd3)
                    state_d = ({shift_q, len_q[23:0]} == 32'd0) ? ST_DONE : ST_DATA;
            end
            ST_DATA: if (byte_stb) begin
                cnt_d = cnt_q + 32'd1;
                asm_d = word;
                if (lane == 2'd3 || last) begin
                    // The pending word may leave on this very edge; only then is there room.
                    if (req_full_q && !req_release) begin
                        state_d = ST_ERR;
                    end else begin
                        wdata_d    = word;
                        wstrb_d    = {lane == 2'd3, lane >= 2'd2, lane >= 2'd1, 1'b1};
                        req_full_d = 1'b1;
                        asm_d      = '0;
                        if (last) state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: if (!req_full_q) state_d = ST_DONE;
            default: ;
        endcase
        if ((frame_err && state_q != ST_DONE) || mismatch) state_d = ST_ERR;
        mem_valid_d = req_full_d && !handshake && (state_q != ST_ERR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            state_q     <= ST_HDR;
            len_q       <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            hdr_idx_q   <= '0;
            req_full_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            wstrb_q     <= '0;
`ifdef UART_BOOT_LOADER_VERIFY_EN
            phase_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            hdr_idx_q   <= hdr_idx_d;
            req_full_q  <= req_full_d;
            mem_valid_q <= mem_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
`ifdef UART_BOOT_LOADER_VERIFY_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_instr = 1'b0;
    assign mem.mem_addr  = addr_q;
`ifdef UART_BOOT_LOADER_VERIFY_EN
    assign mem.mem_wdata = phase_q ? 32'd0 : wdata_q;
    assign mem.mem_wstrb = phase_q ? 4'd0  : wstrb_q;
`else
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;
`endif
    assign done  = (state_q == ST_DONE);
    assign error = (state_q == ST_ERR);
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: UART byte driver, memory responder with a
// write scoreboard, and checks on done/error/valid around each scenario.
module tb_uart_boot_loader;
    localparam int CPB = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wr_t;
    typedef logic [7:0] byte_q_t[$];

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic done, error;
    uart_boot_loader_if bus();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .rx(rx), .mem(bus), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int          nchk = 0;
    int          nfail = 0;
    int          txn_count = 0;
    logic        hold_ready = 1'b0;
    logic        corrupt = 1'b0;
    wr_t         exp_q[$];
    logic [31:0] mem_model [16];
    logic [31:0] last_wr_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_bytes(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) @(negedge clock);
        check("done", {31'd0, done}, 32'd1);
    endtask

    // Memory responder: ready one cycle after valid is first seen, single-cycle pulse.
    initial begin
        int  vcnt;
        wr_t e;
        vcnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                vcnt = 0;
                check("valid_drop", {31'd0, bus.mem_valid}, 32'd0);
            end else if (bus.mem_valid === 1'b1 && !hold_ready) begin
                vcnt++;
                if (vcnt > 1) begin
`ifdef UART_BOOT_LOADER_VERIFY_EN
                    if (bus.mem_wstrb == 4'd0) begin
                        check("rd_addr", bus.mem_addr, last_wr_addr);
                        bus.mem_rdata = mem_model[bus.mem_addr[5:2]] ^ (corrupt ? 32'h00FF_0000 : 32'd0);
                        bus.mem_ready = 1'b1;
                        continue;
                    end
`endif
                    check("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wr_addr", bus.mem_addr, e.addr);
                        check("wr_data", bus.mem_wdata, e.wdata);
                        check("wr_strb", {28'd0, bus.mem_wstrb}, {28'd0, e.wstrb});
                        check("instr", {31'd0, bus.mem_instr}, 32'd0);
                    end
                    for (int l = 0; l < 4; l++)
                        if (bus.mem_wstrb[l])
                            mem_model[bus.mem_addr[5:2]][8*l +: 8] = bus.mem_wdata[8*l +: 8];
                    last_wr_addr = bus.mem_addr;
                    txn_count++;
                    bus.mem_ready = 1'b1;
                end
            end else begin
                vcnt = 0;
            end
        end
    end

    initial begin
        byte_q_t bq;
        int      t0;

        // Reset state with idle line
        do_reset();
        repeat (100) @(negedge clock);
        check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0000_0000);
        check("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);

        // Two full words
        exp_q.push_back('{32'h0000_0000, 32'h4433_2211, 4'b1111});
        exp_q.push_back('{32'h0000_0004, 32'h8877_6655, 4'b1111});
        bq = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_bytes(bq);
        wait_done(500);
        check("t8_error", {31'd0, error}, 32'd0);
        check("t8_sb_empty", exp_q.size(), 32'd0);
        check("t8_addr", bus.mem_addr, 32'h0000_0008);

        // Partial final word
        do_reset();
        exp_q.push_back('{32'h0000_0000, 32'hDDCC_BBAA, 4'b1111});
        exp_q.push_back('{32'h0000_0004, 32'h0000_00EE, 4'b0001});
        bq = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_bytes(bq);
        wait_done(500);
        check("t5_error", {31'd0, error}, 32'd0);
        check("t5_sb_empty", exp_q.size(), 32'd0);

        // Zero length
        do_reset();
        t0 = txn_count;
        bq = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(bq);
        wait_done(20);
        repeat (50) @(negedge clock);
        check("t0_no_txn", txn_count, t0);
        check("t0_valid", {31'd0, bus.mem_valid}, 32'd0);

        // Framing error, ignored traffic, then recovery
        do_reset();
        t0 = txn_count;
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clock);
        check("fe_error", {31'd0, error}, 32'd1);
        check("fe_valid", {31'd0, bus.mem_valid}, 32'd0);
        bq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h77};
        send_bytes(bq);
        repeat (20) @(negedge clock);
        check("fe_sticky", {31'd0, error}, 32'd1);
        check("fe_done", {31'd0, done}, 32'd0);
        check("fe_no_txn", txn_count, t0);
        do_reset();
        check("fe_rst_error", {31'd0, error}, 32'd0);
        exp_q.push_back('{32'h0000_0000, 32'h0403_0201, 4'b1111});
        bq = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_bytes(bq);
        wait_done(500);
        check("fe_reload_sb", exp_q.size(), 32'd0);

        // Overrun with ready withheld
        do_reset();
        hold_ready = 1'b1;
        bq = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        send_bytes(bq);
        check("ov_pre_error", {31'd0, error}, 32'd0);
        check("ov_pre_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("ov_held_data", bus.mem_wdata, 32'h1312_1110);
        send_byte(8'h17, 1'b1);
        check("ov_error", {31'd0, error}, 32'd1);
        check("ov_valid", {31'd0, bus.mem_valid}, 32'd0);
        bq = '{8'h18, 8'h19, 8'h1A, 8'h1B};
        send_bytes(bq);
        check("ov_done", {31'd0, done}, 32'd0);
        do_reset();
        hold_ready = 1'b0;

`ifdef UART_BOOT_LOADER_VERIFY_EN
        // Read-back corrupted in lane 2
        corrupt = 1'b1;
        exp_q.push_back('{32'h0000_0000, 32'h4433_2211, 4'b1111});
        bq = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(bq);
        for (int i = 0; i < 200 && error !== 1'b1; i++) @(negedge clock);
        check("vf_error", {31'd0, error}, 32'd1);
        check("vf_sb_empty", exp_q.size(), 32'd0);
        corrupt = 1'b0;
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Serial boot-load initiator: receives an 8N1 UART byte stream and writes the payload into memory.
- Acts as the initiator side of the SoC memory handshake (valid/instr/addr/wdata/wstrb/rdata/ready).
- The print/UART path is a responder on that handshake; this block drives requests instead.
- Sits between an external rx pin and a RAM/interconnect port; preloads program images before the core leaves reset.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; must be an even value of 4 or more.
BASE_ADDR, 32'h0000_0000, byte address of the first payload word; must be 4-byte aligned.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
rx  input  1  UART serial input, idle high; double-flopped internally.
mem_valid  output  1  request valid.
mem_instr  output  1  instruction-fetch flag; constant 0.
mem_addr  output  32  word-aligned byte address.
mem_wdata  output  32  write data, little-endian byte lanes.
mem_wstrb  output  4  byte enables; 0000 means read.
mem_rdata  input  32  read data; used only with the optional feature.
mem_ready  input  1  responder completion.
done  output  1  sticky; load completed.
error  output  1  sticky; framing, overrun or verify failure.

Behaviour:
- Reset values: mem_valid=0, mem_instr=0, mem_addr=BASE_ADDR, mem_wdata=0, mem_wstrb=0, done=0, error=0.
- Reset asserted mid-transaction drops mem_valid on that edge; the responder tolerates the abandoned request.
- UART receiver, 8N1, LSB first:
  - Start is detected on a sampled 1->0 of the synchronised rx.
  - Start bit is re-checked at CLKS_PER_BIT/2; if it reads 1, treat as a glitch and return to idle.
  - Data bits are sampled every CLKS_PER_BIT cycles after that.
  - Stop bit sampled 0 is a framing error: error=1, FSM goes to ERR.
  - Produces a 1-cycle byte strobe.
- Main FSM: HDR -> DATA -> DRAIN -> DONE; ERR is reachable from any state.
  - HDR: collect 4 bytes into LEN, little-endian (first byte is LEN[7:0]). After the 4th byte: LEN==0 goes straight to DONE, else DATA.
  - DATA: bytes fill a word assembler at lane index cnt[1:0], with cnt counting 0..LEN-1.
    - A word is complete when lane 3 fills or cnt==LEN-1.
    - On completion, the word moves to the request register.
    - For a partial final word of n bytes (n=1..3): wstrb = (1<<n)-1, and unused wdata lanes are 0.
    - After the last byte, go to DRAIN.
  - DRAIN: wait until the request register is empty, then go to DONE.
  - DONE: done=1. Further rx bytes are ignored. Stays until reset.
  - ERR: error=1. mem_valid is dropped next cycle, done stays 0. Stays until reset.
- Bus handshake:
  - mem_valid rises 1 cycle after the word completes.
  - addr, wdata and wstrb are held stable while valid=1.
  - The transaction completes on the first edge with valid & ready; mem_valid=0 the following cycle.
  - There are no back-to-back requests: minimum 1 idle cycle between requests.
  - mem_ready while valid=0 is ignored.
- Address rules:
  - The first write goes to BASE_ADDR; each completed transaction adds 4.
  - Address wraps modulo 2^32 with no error.
- Overrun: a new word completes while the request register is still pending -> error, ERR.
- Same-cycle events: a word completing on the same edge as the pending request's valid&ready is not an overrun; the new request is issued next cycle.

Optional Feature:
- Macro: UART_BOOT_LOADER_VERIFY_EN.
- When defined:
  - Each completed write is followed by a read of the same address (wstrb=0000, wdata=0), one idle cycle after the write handshake.
  - On read valid&ready, mem_rdata is compared against wdata on the enabled lanes only.
  - Mismatch sets error and goes to ERR.
  - The request register is considered empty only after the read completes; overrun checks use this.
- When undefined: writes only; mem_rdata is unused.

Test Plan:
- Reset, rx idle for 100 cycles -> mem_valid=0, done=0, error=0, mem_addr=BASE_ADDR.
- Send header 08 00 00 00, payload 11 22 33 44 55 66 77 88, ready 1 cycle after valid:
  - write 0x00000000 = 0x44332211, wstrb 1111;
  - write 0x00000004 = 0x88776655, wstrb 1111;
  - done=1.
- Header 05 00 00 00, payload AA BB CC DD EE:
  - second write addr 0x00000004, wdata 0x000000EE, wstrb 0001;
  - done=1.
- Header 00 00 00 00 -> no mem_valid pulses; done=1 after 4th byte.
- Byte with stop bit 0 -> error=1, mem_valid stays 0, later bytes ignored; reset clears error and reload succeeds.
- ready withheld for 50*CLKS_PER_BIT cycles with a 12-byte payload:
  - error=1 on 2nd word completion; valid drops next cycle.
  - With VERIFY_EN and rdata corrupted at lane 2: error=1 after the first read.
